// File: rtl/line_clear.sv
// line_clear: removes every fully occupied row from a locked-piece playfield
// and drops the remaining rows to the bottom, one row per clock.
//
// Ports
//   frame_clk   : clock, all state changes on its rising edge
//   Reset       : asynchronous, active-high reset
//   start       : one-cycle request to process grid_in (accepted only when idle)
//   grid_in     : playfield, grid_in[col][row] is a 4-bit colour code, 0 = empty
//   grid_out    : compacted playfield, registered, updated together with done
//   busy        : high whenever a pass is in progress
//   done        : one-cycle pulse, grid_out / lines_last / score valid
//   lines_last  : rows removed by the latest pass, saturating at 4
//   lines_total : cumulative rows removed, saturating at 65535
//   score       : cumulative score, saturating at 2^20-1
//
// Sequence: IDLE -> LOAD (snapshot) -> SCAN (ROWS cycles, bottom row first)
// -> FILL (k cycles, blank the vacated top rows) -> DONE -> IDLE.
module line_clear #(
  parameter int COLS = 10,
  parameter int ROWS = 22
) (
  input  logic                             frame_clk,
  input  logic                             Reset,
  input  logic                             start,
  input  logic [COLS-1:0][ROWS-1:0][3:0]   grid_in,
  output logic [COLS-1:0][ROWS-1:0][3:0]   grid_out,
  output logic                             busy,
  output logic                             done,
  output logic [2:0]                       lines_last,
  output logic [15:0]                      lines_total,
  output logic [19:0]                      score
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int KW = $clog2(ROWS + 1);

  typedef logic [COLS-1:0][ROWS-1:0][3:0] grid_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_FILL, S_DONE} state_t;

  state_t          state;
  grid_t           src;       // snapshot of grid_in taken in LOAD
  grid_t           work;      // compacted result under construction
  grid_t           work_nxt;
  logic [RW-1:0]   r;         // source row being examined
  logic [RW-1:0]   w;         // next destination row in work
  logic [KW-1:0]   k;         // full rows found so far this pass
  logic [KW-1:0]   k_nxt;
  logic [KW-1:0]   k_fin;     // final row count, valid when finishing
  logic            row_full;
  logic            finishing; // this edge enters DONE
  logic [20:0]     score_sum;
  logic [16:0]     total_sum;

  function automatic logic [10:0] score_inc(input logic [KW-1:0] n);
    if (n == 0)      return 11'd0;
    else if (n == 1) return 11'd40;
    else if (n == 2) return 11'd100;
    else if (n == 3) return 11'd300;
    else             return 11'd1200;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default value first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (src[c][r] == 4'd0) row_full = 1'b0;
    end

    k_nxt    = k + KW'(row_full);
    work_nxt = work;
    case (state)
      S_SCAN: begin
        if (!row_full) begin
          for (int c = 0; c < COLS; c++) work_nxt[c][w] = src[c][r];
        end
      end
      S_FILL: begin
        for (int c = 0; c < COLS; c++) work_nxt[c][w] = 4'd0;
      end
      default: ;
    endcase

    finishing = ((state == S_SCAN) && (r == '0) && (k_nxt == '0)) ||
                ((state == S_FILL) && (w == '0));
    k_fin     = (state == S_SCAN) ? k_nxt : k;
    score_sum = {1'b0, score} + 21'(score_inc(k_fin));
    total_sum = {1'b0, lines_total} + 17'(k_fin);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      // NOTE: the playfield buffers are reset explicitly because an aborted
      // pass must leave no stale rows behind; they are plain registers here.
      state       <= S_IDLE;
      src         <= '0;
      work        <= '0;
      grid_out    <= '0;
      r           <= '0;
      w           <= '0;
      k           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      lines_last  <= '0;
      lines_total <= '0;
      score       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          src   <= grid_in;
          work  <= '0;
          r     <= RW'(ROWS - 1);
          w     <= RW'(ROWS - 1);
          k     <= '0;
          state <= S_SCAN;
        end
        S_SCAN: begin
          work <= work_nxt;
          k    <= k_nxt;
          r    <= r - RW'(1);
          if (!row_full) w <= w - RW'(1);
          if (r == '0) state <= (k_nxt == '0) ? S_DONE : S_FILL;
        end
        S_FILL: begin
          work <= work_nxt;
          w    <= w - RW'(1);
          if (w == '0) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Results are published on the same edge that enters DONE, taking the
      // row written on that edge into account.
      if (finishing) begin
        done        <= 1'b1;
        grid_out    <= work_nxt;
        lines_last  <= (k_fin >= KW'(4)) ? 3'd4 : 3'(k_fin);
        lines_total <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
        score       <= score_sum[20] ? 20'hFFFFF : score_sum[19:0];
      end
    end
  end

endmodule

// File: doc/line_clear.md
LINE_CLEAR -- requirements
Module: line_clear

Interface
REQ-001 Parameter COLS, default 10, playfield columns (first grid index).
REQ-002 Parameter ROWS, default 22, playfield rows (second grid index; row 0 top, row ROWS-1 bottom).
REQ-003 frame_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to process grid_in; sampled only in IDLE.
REQ-006 grid_in  input  4 x [COLS][ROWS]  locked-piece playfield; cell nonzero = occupied.
REQ-007 grid_out  output  4 x [COLS][ROWS]  compacted playfield, registered.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse; grid_out, lines_last and score are valid and updated in this cycle.
REQ-010 lines_last  output  3  full rows removed by the most recent pass, saturating at 4.
REQ-011 lines_total  output  16  cumulative rows removed since reset, saturating at 65535.
REQ-012 score  output  20  cumulative score since reset, saturating at 1048575.

Function
REQ-013 The block SHALL implement states IDLE, LOAD, SCAN, FILL, DONE.
REQ-014 IDLE: start=1 -> LOAD; start=0 -> stay; grid_out held unchanged.
REQ-015 LOAD (1 cycle): copy grid_in to internal source buffer, clear work buffer, read ptr r=ROWS-1, write ptr w=ROWS-1, pass count k=0; -> SCAN.
REQ-016 SCAN processes exactly one source row per cycle, from row ROWS-1 upward to row 0 (ROWS cycles).
REQ-017 Row full = all COLS cells nonzero; full row: k increments, w unchanged; non-full row: copy to work row w, w decrements.
REQ-018 After row 0 is processed: k=0 -> DONE; k>0 -> FILL.
REQ-019 FILL zeroes work rows w, w-1, ... 0, one row per cycle (exactly k cycles), then -> DONE.
REQ-020 Edge entering DONE SHALL load grid_out from work buffer and update lines_last, lines_total, score.
REQ-021 DONE lasts 1 cycle with done=1, then -> IDLE.
REQ-022 Total latency start-sampled to done = 1 + ROWS + k + 1 cycles (24 + k at defaults).
REQ-023 Score increment by k: 0->0, 1->40, 2->100, 3->300, >=4 ->1200; add saturates at 2^20-1.
REQ-024 lines_total += k, saturating at 65535; lines_last = min(k,4).
REQ-025 Non-full rows keep original cell values (piece colour codes) and relative order.
REQ-026 start while busy=1 SHALL be ignored, not queued; grid_in changes after LOAD SHALL not affect the pass.
REQ-027 start asserted in the same cycle as done SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-028 Row with zero occupied cells is non-full and is copied like any other.
REQ-029 All rows full: k=ROWS, FILL lasts ROWS cycles, grid_out all zero, lines_last=4, score +1200.

Reset
REQ-030 Reset=1 SHALL immediately force IDLE, grid_out all cells 0, busy=0, done=0, lines_last=0, lines_total=0, score=0, internal buffers and pointers cleared.
REQ-031 Reset asserted mid-pass SHALL abort it with no partial grid_out or counter update; done SHALL not pulse after deassertion.

Verification
REQ-032 Empty grid, start -> done at cycle 24, grid_out all 0, lines_last=0, score=0.
REQ-033 Row 21 full (all 1), cell [3][20]=5, start -> done at cycle 25, grid_out[3][21]=5, row 20 all 0, lines_last=1, score=40.
REQ-034 Rows 18-21 full, [0][17]=2 -> done at cycle 28, grid_out[0][21]=2, lines_last=4, score=1200, lines_total=4.
REQ-035 Rows 21 and 19 full, row 20 = single cell [7][20]=3 -> grid_out[7][21]=3, rows 0-20 empty, lines_last=2, score +100.
REQ-036 Reset pulsed at SCAN cycle 10 of pass clearing 1 row -> busy=0 immediately, grid_out all 0, score=0, no done.
REQ-037 start re-pulsed every cycle during pass -> exactly one done per accepted start; score accumulates once per pass.
